// File: rtl/bpu_pkg.sv
// bpu_pkg: kind/counter constants and saturating counter update for branch_predictor
package bpu_pkg;
  localparam logic [1:0] KIND_COND = 2'd0;
  localparam logic [1:0] KIND_JUMP = 2'd1;
  localparam logic [1:0] KIND_RET  = 2'd2;
  localparam logic [1:0] KIND_RSVD = 2'd3;
  localparam logic [1:0] CTR_SNT   = 2'd0;
  localparam logic [1:0] CTR_WNT   = 2'd1;
  localparam logic [1:0] CTR_WT    = 2'd2;
  localparam logic [1:0] CTR_ST    = 2'd3;
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    return taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1)
                 : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/bpu_ras.sv
// bpu_ras: return address stack, pop-then-push on one edge, oldest entry overwritten on overflow
module bpu_ras #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = DEPTH[PW:0];
  logic [ADDR_WIDTH-1:0] r_stack [DEPTH];
  logic [PW-1:0]         r_ptr;
  logic [PW:0]           r_cnt;
  logic                  w_pop;
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         w_top_idx;
  logic [PW:0]           w_cnt;
  assign w_pop     = pop && (r_cnt != '0);
  assign w_ptr     = w_pop ? r_ptr - 1'b1 : r_ptr;
  assign w_cnt     = w_pop ? r_cnt - 1'b1 : r_cnt;
  assign w_top_idx = r_ptr - 1'b1;
  assign top       = r_stack[w_top_idx];
  assign empty     = (r_cnt == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else if (push) begin
      r_stack[w_ptr] <= push_addr;
      r_ptr          <= w_ptr + 1'b1;
      r_cnt          <= (w_cnt == FULL) ? w_cnt : w_cnt + 1'b1;
    end else begin
      r_ptr <= w_ptr;
      r_cnt <= w_cnt;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; return address stack built under BPU_RAS_EN
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int ENTRIES     = 64,
  parameter int RAS_DEPTH   = 8,
  parameter int LINK_OFFSET = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btb_clear,
  input  logic [ADDR_WIDTH-1:0] pred_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [1:0]            upd_kind,
  input  logic                  upd_call,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  logic                  r_valid  [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [1:0]            r_kind   [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
  logic [1:0]            r_ctr    [ENTRIES];
  logic [IDX_W-1:0]      w_pidx, w_uidx;
  logic [TAG_W-1:0]      w_ptag, w_utag;
  logic                  w_upd, w_uhit, w_use_ras, w_ras_empty, w_unused;
  logic [ADDR_WIDTH-1:0] w_ras_top;
  assign w_pidx      = pred_pc[IDX_W+1:2];
  assign w_ptag      = pred_pc[ADDR_WIDTH-1:IDX_W+2];
  assign w_uidx      = upd_pc[IDX_W+1:2];
  assign w_utag      = upd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign w_upd       = upd_valid && (upd_kind != KIND_RSVD);
  assign w_uhit      = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign pred_hit    = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);
  assign pred_taken  = pred_hit && ((r_kind[w_pidx] != KIND_COND) || r_ctr[w_pidx][1]);
  assign w_use_ras   = (r_kind[w_pidx] == KIND_RET) && !w_ras_empty;
  assign pred_target = !pred_taken ? '0 : (w_use_ras ? w_ras_top : r_target[w_pidx]);
`ifdef BPU_RAS_EN
  bpu_ras #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_upd && upd_call),
    .push_addr(upd_pc + ADDR_WIDTH'(LINK_OFFSET)),
    .pop      (w_upd && (upd_kind == KIND_RET)),
    .top      (w_ras_top),
    .empty    (w_ras_empty)
  );
  assign w_unused = &{1'b0, pred_pc[1:0]};
`else
  assign w_ras_top   = '0;
  assign w_ras_empty = 1'b1;
  assign w_unused    = &{1'b0, pred_pc[1:0], upd_pc[1:0], upd_call, RAS_DEPTH[0], LINK_OFFSET[0]};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_kind[i]   <= KIND_COND;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (btb_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
    end else if (w_upd && w_uhit) begin
      r_tag[w_uidx]  <= w_utag;
      r_kind[w_uidx] <= upd_kind;
      r_ctr[w_uidx]  <= ctr_update(r_ctr[w_uidx], upd_taken);
      if (upd_taken) r_target[w_uidx] <= upd_target;
    end else if (w_upd && upd_taken) begin
      r_valid[w_uidx]  <= 1'b1;
      r_tag[w_uidx]    <= w_utag;
      r_kind[w_uidx]   <= upd_kind;
      r_target[w_uidx] <= upd_target;
      r_ctr[w_uidx]    <= (upd_kind == KIND_COND) ? CTR_WT : CTR_ST;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: random and directed stimulus against a behavioural predictor model
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btb_clear = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [1:0]  upd_kind = '0;
  logic        upd_call = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  int total = 0;
  int bad = 0;
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  int          m_kind  [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic [31:0] m_ras   [$];

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .btb_clear(btb_clear), .pred_pc(pred_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind), .upd_call(upd_call),
    .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_kind[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_ras.delete();
  endtask

  task automatic m_look(input logic [31:0] pc, output logic eh, output logic et, output logic [31:0] etg);
    int i;
    i = int'((pc / 4) % 64);
    eh = m_valid[i] && (m_tag[i] == pc / 256);
    et = eh && (m_kind[i] != 0 || m_ctr[i] >= 2);
    etg = et ? m_tgt[i] : 32'd0;
`ifdef BPU_RAS_EN
    if (et && m_kind[i] == 2 && m_ras.size() > 0) etg = m_ras[$];
`endif
  endtask

  task automatic m_update(input logic uv, input logic [31:0] pc, input int k, input logic call,
                          input logic t, input logic [31:0] tg, input logic clr);
    int i;
    bit hit;
    if (!uv || k == 3) begin
      if (clr) for (int j = 0; j < 64; j++) begin m_valid[j] = 0; m_ctr[j] = 1; end
      return;
    end
    i = int'((pc / 4) % 64);
    hit = m_valid[i] && (m_tag[i] == pc / 256);
    if (clr) begin
      for (int j = 0; j < 64; j++) begin m_valid[j] = 0; m_ctr[j] = 1; end
    end else if (hit) begin
      m_tag[i] = pc / 256;
      m_kind[i] = k;
      m_ctr[i] = t ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (t) m_tgt[i] = tg;
    end else if (t) begin
      m_valid[i] = 1; m_tag[i] = pc / 256; m_kind[i] = k; m_tgt[i] = tg;
      m_ctr[i] = (k == 0) ? 2 : 3;
    end
`ifdef BPU_RAS_EN
    if (k == 2 && m_ras.size() > 0) void'(m_ras.pop_back());
    if (call) begin
      m_ras.push_back(pc + 32'd8);
      if (m_ras.size() > 8) void'(m_ras.pop_front());
    end
`endif
  endtask

  task automatic cyc(input logic [31:0] ppc, input logic uv, input logic [31:0] upc, input int k,
                     input logic call, input logic t, input logic [31:0] tg, input logic clr);
    logic eh, et;
    logic [31:0] etg;
    pred_pc = ppc; upd_valid = uv; upd_pc = upc; upd_kind = 2'(k);
    upd_call = call; upd_taken = t; upd_target = tg; btb_clear = clr;
    #1;
    m_look(ppc, eh, et, etg);
    chk("hit", {31'd0, pred_hit}, {31'd0, eh});
    chk("taken", {31'd0, pred_taken}, {31'd0, et});
    chk("target", pred_target, etg);
    @(posedge clk);
    m_update(uv, upc, k, call, t, tg, clr);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input int k, input logic call, input logic t, input logic [31:0] tg);
    cyc(32'h0040_0000, 1'b1, pc, k, call, t, tg, 1'b0);
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] etg);
    pred_pc = pc; upd_valid = 1'b0; upd_call = 1'b0; btb_clear = 1'b0;
    #1;
    chk({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, eh});
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
    chk({tag, "_target"}, pred_target, etg);
  endtask

  initial begin
    m_reset();
    pred_pc = 32'h0040_0000;
    repeat (3) @(posedge clk);
    #1;
    probe("reset", 32'h0040_0000, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    upd(32'h0040_0010, 0, 1'b0, 1'b1, 32'h0040_0100);
    probe("cond_alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 0, 1'b0, 1'b0, 32'h0);
    upd(32'h0040_0010, 0, 1'b0, 1'b0, 32'h0);
    probe("cond_snt", 32'h0040_0010, 1'b1, 1'b0, 32'h0);
    repeat (3) upd(32'h0040_0010, 0, 1'b0, 1'b1, 32'h0040_0104);
    upd(32'h0040_0010, 0, 1'b0, 1'b0, 32'h0);
    probe("cond_st", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0104);
    upd(32'h0040_0044, 0, 1'b0, 1'b0, 32'h0040_0999);
    probe("miss_nt", 32'h0040_0044, 1'b0, 1'b0, 32'h0);
    upd(32'h0040_0110, 1, 1'b0, 1'b1, 32'h0040_0200);
    probe("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    probe("alias_new", 32'h0040_0110, 1'b1, 1'b1, 32'h0040_0200);
    cyc(32'h0040_0020, 1'b1, 32'h0040_0020, 0, 1'b0, 1'b1, 32'h0040_0300, 1'b0);
    probe("same_cyc", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0300);
    cyc(32'h0040_0000, 1'b1, 32'h0040_0040, 1, 1'b0, 1'b1, 32'h0040_0400, 1'b1);
    probe("clr_upd", 32'h0040_0040, 1'b0, 1'b0, 32'h0);
    probe("clr_old", 32'h0040_0110, 1'b0, 1'b0, 32'h0);
`ifdef BPU_RAS_EN
    upd(32'h0040_0500, 2, 1'b0, 1'b1, 32'h0040_0600);
    probe("ret_empty", 32'h0040_0500, 1'b1, 1'b1, 32'h0040_0600);
    upd(32'h0040_0030, 1, 1'b1, 1'b1, 32'h0040_0700);
    probe("ret_ras", 32'h0040_0500, 1'b1, 1'b1, 32'h0040_0038);
    for (int n = 0; n < 9; n++) upd(32'h0041_0000 + 32'(n * 4), 1, 1'b1, 1'b1, 32'h0040_0700);
    for (int n = 0; n < 9; n++) upd(32'h0040_0500, 2, 1'b0, 1'b1, 32'h0040_0600);
    probe("ras_under", 32'h0040_0500, 1'b1, 1'b1, 32'h0040_0600);
`endif
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc_a, pc_b;
      pc_a = 32'h0040_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      pc_b = 32'h0040_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      cyc(pc_a, 1'($urandom_range(0, 3) != 0), pc_b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 59) == 0));
    end
    upd(32'h0040_0020, 0, 1'b0, 1'b1, 32'h0040_0800);
    probe("pre_rst", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0800);
    pred_pc = 32'h0040_0020; upd_valid = 1'b1; upd_pc = 32'h0040_0070; upd_kind = 2'd0;
    upd_taken = 1'b1; upd_target = 32'h0040_0900;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_hold_target", pred_target, 32'd0);
    upd_valid = 1'b0;
    #2 rst_n = 1'b1;
    m_reset();
    probe("post_rst_alloc", 32'h0040_0070, 1'b0, 1'b0, 32'h0);
    probe("post_rst_old", 32'h0040_0020, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    for (int n = 0; n < 20; n++)
      cyc(32'h0040_0070, 1'b1, 32'h0040_0070, 0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
